// File: rtl/uart_rx_fifo.sv
// Purpose : receive-side byte buffer behind uart_rx; edge-detects rx_ready/rx_error,
//           drops framing-error bytes and queues good bytes in a first-word-fall-through FIFO.
// Latency : a byte whose rx_ready rise is sampled at edge N is visible on rd_data after edge N.
// Backpressure: none toward uart_rx. A byte offered while full (and not popped in the same
//           cycle) is dropped and sets sticky overflow. A pop while empty sets sticky underflow.
//
// Ports:
//   clk50m, rst_n          clock and asynchronous active-low reset
//   rx_data/rx_ready       byte and data-ready level from uart_rx (event = 0->1 of rx_ready)
//   rx_error               framing-error level from uart_rx (event = 0->1)
//   rd_en                  consumer pop request
//   clr_flags              synchronous clear of overflow, underflow and err_cnt
//   rd_data                head entry, valid while empty=0 (reads 8'h00 while empty)
//   empty/full/count       fill state, all derived from one registered count
//   overflow/underflow     sticky status flags
//   err_cnt                saturating count of rx_error rising edges
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk50m,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    input  logic                       rx_error,
    input  logic                       rd_en,
    input  logic                       clr_flags,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // Edge detection of the uart_rx level flags
    // ------------------------------------------------------------------
    // Both history registers come out of reset high so that a level already
    // asserted when reset is released is not mistaken for a new event.
    logic rdy_q;
    logic err_q;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b1;
            err_q <= 1'b1;
        end else begin
            rdy_q <= rx_ready;
            err_q <= rx_error;
        end
    end

    logic push_evt;
    logic err_evt;

    // A frame flagged bad at the moment rx_ready rises is never offered.
    assign push_evt = rx_ready & ~rdy_q & ~rx_error;
    assign err_evt  = rx_error & ~err_q;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    logic pop_ok;
    logic push_ok;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when it coincides with a legal pop.
    assign pop_ok  = rd_en & ~empty;
    assign push_ok = push_evt & (~full | pop_ok);

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk50m) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_nxt;
        end
    end

    // First-word fall-through head. Forced to zero while empty so the output
    // is defined out of reset even though the storage itself is not reset.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    // ------------------------------------------------------------------
    // Sticky status and error counter
    // ------------------------------------------------------------------
    logic ovf_set;
    logic udf_set;

    assign ovf_set = push_evt & full & ~pop_ok;
    assign udf_set = rd_en & empty;

    // clr_flags takes priority over a same-cycle set or increment.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err_cnt   <= '0;
        end else if (clr_flags) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end
            if (err_evt && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed self-checking bench for uart_rx_fifo (DEPTH=16, ERR_CNT_W=8).
// Latency : inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next.
// Backpressure: not applicable; the bench drives every cycle explicitly.
module tb_uart_rx_fifo;

    logic       clk50m;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       rd_en;
    logic       clr_flags;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic [7:0] err_cnt;

    int n_total;
    int n_pass;

    uart_rx_fifo #(
        .DEPTH     (16),
        .ERR_CNT_W (8)
    ) dut (
        .clk50m    (clk50m),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_error  (rx_error),
        .rd_en     (rd_en),
        .clr_flags (clr_flags),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .err_cnt   (err_cnt)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    // Advance one clock; return 1 ns after the edge.
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    // Offer one byte: rx_ready high for one cycle, then low for one cycle.
    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_ready = 1'b1;
        rx_error = 1'b1;
        rx_data = 8'h3C;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else n_pass++;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
        n_total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else n_pass++;
        rx_ready = 1'b0;
        rx_error = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        rx_data  = 8'h55;
        rx_ready = 1'b1;
        tick();
        n_total++; if (empty !== 1'b0) $display("FAIL single_empty got %b want 0", empty); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL single_count got %0d want 1", count); else n_pass++;
        n_total++; if (rd_data !== 8'h55) $display("FAIL single_rd_data got %h want 55", rd_data); else n_pass++;
        rx_ready = 1'b0;
        pop_one();
        n_total++; if (empty !== 1'b1) $display("FAIL single_pop_empty got %b want 1", empty); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL single_pop_count got %0d want 0", count); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL single_underflow got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_error_frame();
        rx_data  = 8'h00;
        rx_ready = 1'b1;
        rx_error = 1'b1;
        tick();
        n_total++; if (count !== 5'd0) $display("FAIL errfrm_count got %0d want 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL errfrm_empty got %b want 1", empty); else n_pass++;
        n_total++; if (err_cnt !== 8'd1) $display("FAIL errfrm_err_cnt got %0d want 1", err_cnt); else n_pass++;
        rx_ready = 1'b0;
        rx_error = 1'b0;
        tick();
        clear_flags();
        n_total++; if (err_cnt !== 8'd0) $display("FAIL errfrm_clr got %0d want 0", err_cnt); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL fill_count got %0d want 16", count); else n_pass++;
        push_byte(8'hAA);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (rd_data !== 8'(i)) $display("FAIL drain_data idx %0d got %h want %h", i, rd_data, 8'(i));
            else n_pass++;
            pop_one();
        end
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
        clear_flags();
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_wrap_concurrency();
        for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (rd_data !== 8'h20 + 8'(i)) $display("FAIL wrap1 idx %0d got %h want %h", i, rd_data, 8'h20 + 8'(i));
            else n_pass++;
            pop_one();
        end
        for (int i = 0; i < 10; i++) push_byte(8'h40 + 8'(i));
        n_total++; if (count !== 5'd10) $display("FAIL wrap2_count got %0d want 10", count); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (rd_data !== 8'h40 + 8'(i)) $display("FAIL wrap2 idx %0d got %h want %h", i, rd_data, 8'h40 + 8'(i));
            else n_pass++;
            pop_one();
        end
        // Push and pop together while full.
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        n_total++; if (count !== 5'd16) $display("FAIL fullpp_count got %0d want 16", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fullpp_overflow got %b want 0", overflow); else n_pass++;
        n_total++; if (full !== 1'b1) $display("FAIL fullpp_full got %b want 1", full); else n_pass++;
        for (int i = 1; i < 16; i++) begin
            n_total++;
            if (rd_data !== 8'h60 + 8'(i)) $display("FAIL fullpp_data idx %0d got %h want %h", i, rd_data, 8'h60 + 8'(i));
            else n_pass++;
            pop_one();
        end
        n_total++; if (rd_data !== 8'h77) $display("FAIL fullpp_last got %h want 77", rd_data); else n_pass++;
        pop_one();
        n_total++; if (empty !== 1'b1) $display("FAIL fullpp_empty got %b want 1", empty); else n_pass++;
        // Push and pop together while empty.
        rx_data  = 8'h99;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        n_total++; if (count !== 5'd1) $display("FAIL emptypp_count got %0d want 1", count); else n_pass++;
        n_total++; if (underflow !== 1'b1) $display("FAIL emptypp_underflow got %b want 1", underflow); else n_pass++;
        n_total++; if (rd_data !== 8'h99) $display("FAIL emptypp_data got %h want 99", rd_data); else n_pass++;
        pop_one();
        clear_flags();
        n_total++; if (underflow !== 1'b0) $display("FAIL udf_clr got %b want 0", underflow); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL emptypp_drain got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_saturation_underflow();
        for (int i = 0; i < 260; i++) begin
            rx_error = 1'b1;
            tick();
            rx_error = 1'b0;
            tick();
            if (i == 9) begin
                n_total++;
                if (err_cnt !== 8'd10) $display("FAIL errcnt_10 got %0d want 10", err_cnt); else n_pass++;
            end
        end
        n_total++; if (err_cnt !== 8'd255) $display("FAIL errcnt_sat got %0d want 255", err_cnt); else n_pass++;
        // Clear wins over a coincident error edge.
        rx_error  = 1'b1;
        clr_flags = 1'b1;
        tick();
        rx_error  = 1'b0;
        clr_flags = 1'b0;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL errcnt_clr_wins got %0d want 0", err_cnt); else n_pass++;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_total++; if (underflow !== 1'b1) $display("FAIL underflow_flag got %b want 1", underflow); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL underflow_count got %0d want 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL underflow_empty got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_reset_mid();
        push_byte(8'hC1);
        push_byte(8'hC2);
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        n_total++; if (count !== 5'd2) $display("FAIL midrst_pre_count got %0d want 2", count); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (count !== 5'd0) $display("FAIL midrst_count got %0d want 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL midrst_empty got %b want 1", empty); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL midrst_underflow got %b want 0", underflow); else n_pass++;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        push_byte(8'hD4);
        n_total++; if (rd_data !== 8'hD4) $display("FAIL midrst_after got %h want d4", rd_data); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL midrst_after_count got %0d want 1", count); else n_pass++;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_ready  = 1'b0;
        rx_error  = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        test_reset();
        test_single_byte();
        test_error_frame();
        test_fill_overflow();
        test_wrap_concurrency();
        test_saturation_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of uart_rx in the 50 MHz domain. It captures each correctly framed byte on the rising edge of rx_ready, discards frames flagged by rx_error, and stores accepted bytes in a first-word-fall-through FIFO for a consumer (CPU bus or command parser). It also keeps sticky overflow/underflow flags and a saturating framing-error counter.

Parameters:
DEPTH, 16, FIFO entries; power of two, legal range 2..256.
ERR_CNT_W, 8, width of the framing-error counter.

Ports:
clk50m  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from uart_rx; valid while rx_ready=1
rx_ready  input  1  uart_rx data-ready level flag; a byte is offered on its 0->1 transition
rx_error  input  1  uart_rx framing-error level flag
rd_en  input  1  pop request from the consumer
clr_flags  input  1  synchronous clear of overflow, underflow and err_cnt
rd_data  output  8  head entry (FWFT); valid while empty=0
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky: a byte was dropped because the FIFO was full
underflow  output  1  sticky: rd_en was asserted while empty
err_cnt  output  ERR_CNT_W  saturating count of rx_error rising edges

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, err_cnt=0, rd_data=8'h00 (memory contents don't-care). rdy_q and err_q (edge-detect registers) reset to 1, so a level already high when reset is released is not taken as an event.
- Reset mid-operation discards all stored bytes and flags immediately. No partial state survives.
- push_evt = rx_ready & ~rdy_q & ~rx_error, sampled on a clk50m rising edge.
- A frame with rx_error=1 at the rx_ready rising edge is never written.
- err_evt = rx_error & ~err_q. It increments err_cnt, which saturates at all-ones and does not wrap.
- Write: on push_evt with full=0, mem[wr_ptr] <= rx_data and wr_ptr increments modulo DEPTH.
- On push_evt with full=1 and no pop in the same cycle: the byte is dropped, overflow <= 1, and pointers and count are unchanged.
- Read: rd_data = mem[rd_ptr] (FWFT). On rd_en with empty=0, rd_ptr increments modulo DEPTH.
- On rd_en with empty=1: no pointer change and underflow <= 1.
- Simultaneous push and pop (both legal): both occur and count is unchanged.
- Simultaneous push and pop while full: the pop frees the slot, the push is accepted, count stays DEPTH, and overflow is not set.
- Simultaneous push and pop while empty: the push is accepted, the pop is an underflow (underflow <= 1), and count becomes 1.
- Latency: for a rx_ready 0->1 sampled at edge N, the entry is written at edge N. After edge N, empty=0, count is updated and rd_data shows the byte (1 cycle from sampling to visibility). A pop at edge M makes the next entry visible after edge M.
- count, empty and full are registered and derived from one count register: empty=(count==0), full=(count==DEPTH).
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- clr_flags=1 clears overflow, underflow and err_cnt at the next edge. If err_evt occurs in the same cycle, the clear wins and err_cnt=0.
- clr_flags has no effect on FIFO contents.
- rx_idle of uart_rx is not used by this block.

Test Plan:
- Reset/idle: hold rst_n=0 with rx_ready=1, then release -> empty=1, count=0, all flags 0. No push occurs although rx_ready is already high.
- Single byte: pulse rx_ready 0->1 with rx_data=8'h55 and rx_error=0 -> one cycle later empty=0, count=1, rd_data=8'h55. Then rd_en for 1 cycle -> empty=1, count=0.
- Error frame: rx_ready rises together with rx_error=1 and rx_data=8'h00 -> nothing stored (count=0) and err_cnt=1. Then clr_flags=1 -> err_cnt=0.
- Fill/overflow: push 8'h00..8'h0F (DEPTH=16) -> full=1, count=16. Push 8'hAA -> overflow=1, count=16. Pop 16 times -> data 8'h00..8'h0F in order, then empty=1.
- Wrap and concurrency: push 10 bytes, pop 10, then push 10 more -> pointers wrap and data order is preserved. With full=1, push 8'h77 and pop in the same cycle -> count=16, overflow=0, and 8'h77 is the last byte read.
- Saturation and underflow: generate 260 rx_error rising edges with ERR_CNT_W=8 -> err_cnt=255. Assert rd_en while empty -> underflow=1 and count stays 0.
